detrust_monitor: RTL and testbench
==================================

# detrust_monitor

Sequence monitor downstream of the Detrust trigger stage. Consumes the registered `t` and `j` trigger flags and confirms a Trojan activation only when `j` follows `t` within a bounded window. Counts confirmed hits and expired windows, and raises a registered `alarm` once the hit count reaches a threshold. The alarm is handed to the system controller over an ack handshake.

## Interface
- `WINDOW`, default 8: cycles after `t` during which `j` counts as a hit; must be ≥ 1.
- `THRESH`, default 1: number of confirmed hits needed to raise `alarm`; must be ≥ 1 and ≤ 2^CNT_W−1.
- `CNT_W`, default 8: width of the hit and miss counters.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `t` in 1: first-stage trigger flag from Detrust; sampled every edge.
- `j` in 1: second-stage trigger flag from Detrust; sampled every edge.
- `alarm_ack` in 1: controller acknowledge; sampled only in ALARM.
- `alarm` out 1: registered; high while in ALARM.
- `armed` out 1: registered; high while in ARMED.
- `hit_cnt` out CNT_W: confirmed hits since reset or last ack; saturating.
- `miss_cnt` out CNT_W: expired windows since reset; saturating, cleared only by reset.

## Operation
- Reset (`rst_n`=0, async): state goes to IDLE, window counter to 0. `alarm`=0, `armed`=0, `hit_cnt`=0, `miss_cnt`=0.
- FSM states: IDLE, ARMED, ALARM.
- IDLE:
  - `t`=1 → ARMED; load window counter with WINDOW.
  - `j` alone is ignored.
  - `t` and `j` together → ARMED only. A `j` only counts if sampled strictly after `t`.
- ARMED: the window counter decrements every edge.
  - `j`=1 → hit; `hit_cnt` +1, saturating.
    - If the new `hit_cnt` ≥ THRESH → ALARM.
    - Otherwise → IDLE.
  - Else `t`=1 → re-arm; reload window counter with WINDOW and stay in ARMED.
  - Else if the counter reaches 0 on this edge → miss; `miss_cnt` +1 (saturating); → IDLE.
  - `t` and `j` together: the hit takes priority; `t` is discarded.
- ALARM: `t` and `j` are ignored; counters are frozen.
  - `alarm_ack`=1 → clear `hit_cnt` to 0; → IDLE.
- Saturation: counters stop at 2^CNT_W−1 and never wrap.
- The window counter is $clog2(WINDOW+1) bits wide.

## Timing
- All outputs are registered; no combinational input-to-output path.
- `t` high in cycle k:
  - `armed`=1 from cycle k+1.
  - `j` in cycles k+1 … k+WINDOW is a hit.
  - `j` in cycle k+WINDOW+1 or later is not a hit.
- Hit in cycle m: `hit_cnt` updates and `alarm` (if threshold met) rises in cycle m+1. `armed` falls in m+1.
- Miss: `miss_cnt` increments and `armed` falls in cycle k+WINDOW+1.
- Ack sampled in cycle a: `alarm`=0 and `hit_cnt`=0 in cycle a+1.
  - A new `t` is accepted from cycle a+1.
  - Holding `alarm_ack` high outside ALARM has no effect.
- `rst_n` asserted mid-window or mid-alarm: all outputs go to 0 immediately, without waiting for a clock edge. Deassertion is expected synchronous to `clk`.

## Configuration
- `DETRUST_MON_STICKY_EN` defined:
  - ALARM is terminal; `alarm_ack` is ignored.
  - `alarm` stays high and `hit_cnt` stays frozen until `rst_n`.
- Not defined: ack-cleared behaviour as described above.

## Test plan
- Reset: drive `rst_n`=0 with `t`=`j`=1 → `alarm`=0, `armed`=0, `hit_cnt`=0, `miss_cnt`=0. Apply `rst_n`=0 in ARMED and check the outputs clear before the next edge.
- Hit/alarm (WINDOW=8, THRESH=1): `t` in cycle 0, `j` in cycle 3 → `armed`=1 in cycles 1–3, `hit_cnt`=1 and `alarm`=1 from cycle 4. `alarm` is held until `alarm_ack` in cycle 10, then `alarm`=0 and `hit_cnt`=0 in cycle 11.
- Window boundary: `t` in cycle 0, `j` in cycle 8 → hit. Repeat with `j` in cycle 9 → `miss_cnt`=1 in cycle 9, `hit_cnt`=0, and the `j` is ignored.
- Threshold (THRESH=3): three t→j pairs spaced 20 cycles apart → `hit_cnt` reads 1, then 2, with `alarm` low. `alarm` rises only after the third `j`.
- Re-arm and priority: `t` in cycles 0 and 6, `j` in cycle 13 → hit (window restarted at 6). `t` and `j` together in IDLE → ARMED with `hit_cnt` unchanged.
- Sticky (`DETRUST_MON_STICKY_EN` defined): reach ALARM and pulse `alarm_ack` → `alarm` stays 1 and `t`/`j` have no effect. Only `rst_n` clears it.

Source files
------------

// File: rtl/detrust_monitor.sv
// Confirms Detrust t->j trigger sequences within a WINDOW-cycle window, counts hits/misses, raises alarm at THRESH hits.
// Define DETRUST_MON_STICKY_EN to make ALARM terminal until reset (alarm_ack ignored).
module detrust_monitor #(
  parameter int WINDOW = 8,
  parameter int THRESH = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             t,
  input  logic             j,
  input  logic             alarm_ack,
  output logic             alarm,
  output logic             armed,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int WC = $clog2(WINDOW + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [WC-1:0]    WIN_LD  = WC'(WINDOW);
  localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);

  typedef enum logic [1:0] {IDLE, ARMED, ALARM} state_t;

  state_t           state_q, state_d;
  logic [WC-1:0]    win_q, win_d;
  logic [CNT_W-1:0] hit_q, hit_d, miss_q, miss_d, hit_inc, miss_inc;

  assign hit_inc  = (hit_q  == CNT_MAX) ? hit_q  : hit_q  + CNT_W'(1);
  assign miss_inc = (miss_q == CNT_MAX) ? miss_q : miss_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    case (state_q)
      IDLE: begin
        // A j sampled together with t is not "after" t, so it is dropped here.
        if (t) begin
          state_d = ARMED;
          win_d   = WIN_LD;
        end
      end
      ARMED: begin
        if (j) begin
          hit_d   = hit_inc;
          state_d = (hit_inc >= THR) ? ALARM : IDLE;
          win_d   = '0;
        end else if (t) begin
          win_d = WIN_LD;
        end else if (win_q <= WC'(1)) begin
          miss_d  = miss_inc;
          state_d = IDLE;
          win_d   = '0;
        end else begin
          win_d = win_q - WC'(1);
        end
      end
      ALARM: begin
`ifdef DETRUST_MON_STICKY_EN
        state_d = ALARM;
`else
        if (alarm_ack) begin
          hit_d   = '0;
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
      alarm   <= 1'b0;
      armed   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      alarm   <= (state_d == ALARM);
      armed   <= (state_d == ARMED);
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;

endmodule

// File: tb/tb_detrust_monitor.sv
// Directed bench for detrust_monitor: two instances (THRESH=1 and THRESH=3) share one stimulus stream.
module tb_detrust_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic t = 1'b0, j = 1'b0, alarm_ack = 1'b0;

  logic       alarm1, armed1, alarm3, armed3;
  logic [7:0] hit1, miss1, hit3, miss3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  detrust_monitor #(.WINDOW(8), .THRESH(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .t(t), .j(j), .alarm_ack(alarm_ack),
    .alarm(alarm1), .armed(armed1), .hit_cnt(hit1), .miss_cnt(miss1)
  );

  detrust_monitor #(.WINDOW(8), .THRESH(3), .CNT_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .t(t), .j(j), .alarm_ack(alarm_ack),
    .alarm(alarm3), .armed(armed3), .hit_cnt(hit3), .miss_cnt(miss3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs; return #1 after the edge that samples them.
  task automatic step(input logic tv, input logic jv, input logic av);
    t = tv; j = jv; alarm_ack = av;
    @(posedge clk);
    #1;
    t = 1'b0; j = 1'b0; alarm_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; t = 1'b1; j = 1'b1; alarm_ack = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1; t = 1'b0; j = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with t=j=1 held
    rst_n = 1'b0; t = 1'b1; j = 1'b1;
    #12;
    check("rst_alarm", alarm1, 0);
    check("rst_armed", armed1, 0);
    check("rst_hit",   hit1,   0);
    check("rst_miss",  miss1,  0);
    @(posedge clk); #1;
    rst_n = 1'b1; t = 1'b0; j = 1'b0;

    // Hit/alarm: t@0, j@3, ack@10
    step(1, 0, 0);
    check("ha_armed_c1", armed1, 1);
    idle(2);
    check("ha_armed_c3", armed1, 1);
    step(0, 1, 0);
    check("ha_hit_c4",   hit1,   1);
    check("ha_alarm_c4", alarm1, 1);
    check("ha_armed_c4", armed1, 0);
    check("ha_hit3_c4",  hit3,   1);
    check("ha_alarm3_c4", alarm3, 0);
    idle(6);
    check("ha_alarm_c10", alarm1, 1);
    step(0, 0, 1);
`ifdef DETRUST_MON_STICKY_EN
    check("st_alarm_ack", alarm1, 1);
    check("st_hit_ack",   hit1,   1);
    step(1, 0, 0);
    step(0, 1, 0);
    check("st_alarm_tj", alarm1, 1);
    check("st_armed_tj", armed1, 0);
    check("st_hit_tj",   hit1,   1);
    rst_n = 1'b0;
    #2;
    check("st_alarm_rst", alarm1, 0);
    check("st_hit_rst",   hit1,   0);
    @(posedge clk); #1;
    rst_n = 1'b1;
`else
    check("ha_alarm_c11", alarm1, 0);
    check("ha_hit_c11",   hit1,   0);
    check("ack_outside_alarm", hit3, 1);
    step(1, 0, 0);
    check("ha_rearm_c12", armed1, 1);
`endif

    // Window boundary: j in last cycle of window is a hit
    do_reset();
    step(1, 0, 0);
    idle(7);
    check("wb_armed_c8", armed1, 1);
    step(0, 1, 0);
    check("wb_hit_c9",  hit1,   1);
    check("wb_alarm_c9", alarm1, 1);
    check("wb_miss_c9", miss1,  0);

    // One cycle later: miss, and the j is ignored
    do_reset();
    step(1, 0, 0);
    idle(7);
    check("wb2_miss_c8", miss1, 0);
    idle(1);
    check("wb2_miss_c9",  miss1,  1);
    check("wb2_armed_c9", armed1, 0);
    step(0, 1, 0);
    check("wb2_hit_c10",  hit1,  0);
    check("wb2_miss_c10", miss1, 1);
    check("wb2_alarm_c10", alarm1, 0);

    // Threshold 3 on dut3
    do_reset();
    for (int p = 1; p <= 3; p++) begin
      step(1, 0, 0);
      idle(2);
      step(0, 1, 0);
      check("thr_hit",   hit3,   p);
      check("thr_alarm", alarm3, (p == 3) ? 1 : 0);
      idle(16);
    end
    check("thr_miss", miss3, 0);

    // Re-arm: t@0 and t@6, j@13 is a hit
    do_reset();
    step(1, 0, 0);
    idle(5);
    step(1, 0, 0);
    idle(6);
    check("ra_armed_c13", armed1, 1);
    check("ra_miss_c13",  miss1,  0);
    step(0, 1, 0);
    check("ra_hit_c14",  hit1,  1);
    check("ra_miss_c14", miss1, 0);

    // t and j together in IDLE: arm only
    do_reset();
    step(1, 1, 0);
    check("tj_armed", armed1, 1);
    check("tj_hit",   hit1,   0);
    idle(1);
    check("tj_hit2",  hit1,   0);

    // Async reset mid-window clears outputs before the next edge
    rst_n = 1'b0;
    #2;
    check("ar_armed", armed1, 0);
    check("ar_alarm", alarm1, 0);
    check("ar_hit",   hit1,   0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
